fifo_sync_param: RTL

Parametrised single-clock FIFO, the next generation of the synchronous FIFO.
- Supports any depth, not only powers of two, and any data width.
- Adds an occupancy count, almost-full/almost-empty thresholds, overflow/underflow error pulses and a read-valid strobe.
- Used as the general buffering element between producer and consumer blocks in the same clock domain.

---
 rtl/fifo_sync_param_if.sv | 33 +++
 rtl/fifo_sync_param.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake bundle between a producer/consumer pair and fifo_sync_param.
// The master side drives write/read requests; the slave side is the FIFO itself.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, wdata, r_en,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, wdata, r_en,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO (any depth) with count, threshold flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_r;
  logic [ADDR_WIDTH-1:0] r_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  af_r;
  logic                  ae_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Pointers wrap explicitly so non-power-of-two depths never index past the array.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    logic [ADDR_WIDTH-1:0] n;
    if (p == PTR_LAST) begin
      n = '0;
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction

  assign wr_acc_s = bus.w_en & ~full_r;
  assign rd_acc_s = bus.r_en & ~empty_r;

  // Next occupancy from the accepted requests
  always_comb begin
    count_nxt_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + 1'b1;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - 1'b1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy, flags (decoded from the next count) and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_r     <= '0;
      r_ptr_r     <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      af_r        <= (CNT_AF == '0);
      ae_r        <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        w_ptr_r <= ptr_inc(w_ptr_r);
      end
      if (rd_acc_s) begin
        r_ptr_r <= ptr_inc(r_ptr_r);
      end
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == CNT_FULL);
      empty_r     <= (count_nxt_s == '0);
      af_r        <= (count_nxt_s >= CNT_AF);
      ae_r        <= (count_nxt_s <= CNT_AE);
      overflow_r  <= bus.w_en & full_r;
      underflow_r <= bus.r_en & empty_r;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[w_ptr_r] <= bus.wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented combinationally; r_en only acknowledges it.
  assign bus.rdata  = mem_r[r_ptr_r];
  assign bus.rvalid = ~empty_r;
`else
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rvalid_r;

  // Registered read port; rdata holds between accepted reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rdata_r <= mem_r[r_ptr_r];
      end
      rvalid_r <= rd_acc_s;
    end
  end

  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;
`endif

  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule
